// File: rtl/dual_issue_queue.sv
// dual_issue_queue: fetch PC owner, circular instruction buffer and in-order pair-issue unit.
// Optional feature macro: DUAL_ISSUE_EN (undefined = single-issue build, lane 2 never valid).
`default_nettype none

module dual_issue_queue #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PCF,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_instr0,
  input  logic [31:0] fetch_instr1,
  output logic        fetch_ready,
  input  logic        StallDecode1,
  input  logic        StallDecode2,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] InstrD1,
  output logic [31:0] PCD1,
  output logic        ValidD1,
  output logic [31:0] InstrD2,
  output logic [31:0] PCD2,
  output logic        ValidD2
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [AW:0] RDY_MAX = (AW+1)'(DEPTH - 2);

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW-1:0] head_p1, tail_p1;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   pcf_q, pcf_d;
  logic          push, stall, v2;
  logic [1:0]    pop_n;

  assign head_p1 = head_q + AW'(1);
  assign tail_p1 = tail_q + AW'(1);

  assign PCF         = pcf_q;
  assign fetch_ready = (count_q <= RDY_MAX);
  assign push        = fetch_valid && fetch_ready;
  assign stall       = StallDecode1 | StallDecode2;

  assign ValidD1 = (count_q != '0);
  assign InstrD1 = instr_q[head_q];
  assign PCD1    = pc_q[head_q];

`ifdef DUAL_ISSUE_EN
  logic [31:0] lane2_instr;
  logic [6:0]  op1;
  logic [4:0]  rd1;
  logic        ctl, writes_rd, dep;

  assign lane2_instr = instr_q[head_p1];
  assign op1         = InstrD1[6:0];
  assign rd1         = InstrD1[11:7];
  assign ctl         = (op1 == 7'b1100011) || (op1 == 7'b1101111) || (op1 == 7'b1100111);
  assign writes_rd   = (op1 != 7'b1100011) && (op1 != 7'b0100011);
  assign dep         = writes_rd && (rd1 != 5'd0) &&
                       ((rd1 == lane2_instr[19:15]) || (rd1 == lane2_instr[24:20]));
  assign v2          = (count_q >= (AW+1)'(2)) && !dep && !ctl;
  assign InstrD2     = v2 ? lane2_instr : NOP;
  assign PCD2        = v2 ? pc_q[head_p1] : PCD1 + 32'd4;
`else
  assign v2      = 1'b0;
  assign InstrD2 = NOP;
  assign PCD2    = PCD1 + 32'd4;
`endif

  assign ValidD2 = v2;
  assign pop_n   = stall ? 2'd0 : ({1'b0, ValidD1} + {1'b0, v2});

  // Redirect wins over push and pop: the queue empties and fetch restarts at the target.
  always_comb begin
    head_d  = head_q + AW'(pop_n);
    tail_d  = push ? tail_q + AW'(2) : tail_q;
    count_d = count_q + (push ? (AW+1)'(2) : '0) - (AW+1)'(pop_n);
    pcf_d   = push ? pcf_q + 32'd8 : pcf_q;
    if (redirect_valid) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pcf_d   = redirect_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pcf_q   <= RESET_PC;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      pcf_q   <= pcf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !redirect_valid) begin
      instr_q[tail_q]  <= fetch_instr0;
      pc_q[tail_q]     <= pcf_q;
      instr_q[tail_p1] <= fetch_instr1;
      pc_q[tail_p1]    <= pcf_q + 32'd4;
    end
  end

endmodule

`default_nettype wire
